// File: rtl/gfx_pkg.sv
// Shared text/graphics constants, state encoding and pixel pipeline payload.
package gfx_pkg;

  localparam int unsigned CELL_W     = 16;
  localparam int unsigned CELL_SHIFT = 4;
  localparam int unsigned COORD_W    = 12;
  localparam int unsigned CHAR_W     = 7;

  localparam logic [CHAR_W-1:0] ASC_SPACE = 7'h20;
  localparam logic [CHAR_W-1:0] ASC_TILDE = 7'h7E;
  localparam logic [CHAR_W-1:0] ASC_BS    = 7'h08;
  localparam logic [CHAR_W-1:0] ASC_LF    = 7'h0A;
  localparam logic [CHAR_W-1:0] ASC_FF    = 7'h0C;

  typedef enum logic {TB_IDLE, TB_CLEAR} tb_state_t;

  // Pixel coordinate bundle carried alongside the character lookup.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               active;
  } pix_t;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
module text_ram #(
  parameter int unsigned DEPTH  = 1200,
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; a same-cycle write to raddr is not visible (old data returned).
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Character-cell frame store: maps each pixel to its cell's ASCII code with
// 2-cycle latency, and accepts printable/control characters at a cursor.
module text_buffer
  import gfx_pkg::*;
#(
  parameter int unsigned COLS = 40,
  parameter int unsigned ROWS = 30
) (
  input  logic                     pix_clk,
  input  logic                     rst_n,
  input  logic [COORD_W-1:0]       i_x,
  input  logic [COORD_W-1:0]       i_y,
  input  logic                     i_active,
  output logic [COORD_W-1:0]       o_x,
  output logic [COORD_W-1:0]       o_y,
  output logic                     o_active,
  output logic [CHAR_W-1:0]        o_character,
  input  logic                     i_char_valid,
  input  logic [CHAR_W-1:0]        i_char,
  output logic                     o_char_ready,
  output logic [$clog2(COLS)-1:0]  o_cur_col,
  output logic [$clog2(ROWS)-1:0]  o_cur_row
);

  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = $clog2(CELLS);
  localparam int unsigned CELL_IDX_W = COORD_W - CELL_SHIFT;

  // ---------------- read path ----------------
  logic [CELL_IDX_W-1:0] rd_col_c, rd_row_c;
  logic                  rd_in_range_c;
  logic [ADDR_W-1:0]     rd_addr_c, rd_addr_q;
  pix_t                  pix_q1, pix_q2;
  logic                  rng_q1, rng_q2;
  logic [CHAR_W-1:0]     ram_rdata;

  assign rd_col_c      = i_x[COORD_W-1:CELL_SHIFT];
  assign rd_row_c      = i_y[COORD_W-1:CELL_SHIFT];
  assign rd_in_range_c = (rd_col_c < CELL_IDX_W'(COLS)) && (rd_row_c < CELL_IDX_W'(ROWS));
  assign rd_addr_c     = ADDR_W'(rd_row_c) * ADDR_W'(COLS) + ADDR_W'(rd_col_c);

  // Two-stage pixel pipeline: stage 1 holds address/coords, stage 2 aligns with RAM data.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      pix_q1    <= '0;
      pix_q2    <= '0;
      rng_q1    <= 1'b0;
      rng_q2    <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_c;
      pix_q1    <= '{x: i_x, y: i_y, active: i_active};
      pix_q2    <= pix_q1;
      rng_q1    <= rd_in_range_c;
      rng_q2    <= rng_q1;
    end
  end

  assign o_x         = pix_q2.x;
  assign o_y         = pix_q2.y;
  assign o_active    = pix_q2.active;
  assign o_character = rng_q2 ? ram_rdata : ASC_SPACE;

  // ---------------- write path / FSM ----------------
  tb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [COL_W-1:0]  cur_col_q, cur_col_d, col_dec_c;
  logic [ROW_W-1:0]  cur_row_q, cur_row_d, row_inc_c;
  logic              ready_q;
  logic              accept_c;
  logic              we_c;
  logic [ADDR_W-1:0] waddr_c, cur_addr_c;
  logic [CHAR_W-1:0] wdata_c;

  assign accept_c   = i_char_valid && ready_q;
  assign col_dec_c  = cur_col_q - COL_W'(1);
  assign row_inc_c  = (cur_row_q == ROW_W'(ROWS - 1)) ? '0 : cur_row_q + ROW_W'(1);
  assign cur_addr_c = ADDR_W'(cur_row_q) * ADDR_W'(COLS) + ADDR_W'(cur_col_q);

  // State, cursor, clear pointer and ready registers.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TB_CLEAR;
      clr_addr_q <= '0;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cur_col_q  <= cur_col_d;
      cur_row_q  <= cur_row_d;
      ready_q    <= (state_d == TB_IDLE);
    end
  end

  // Next-state, cursor update and RAM write decode.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cur_col_d  = cur_col_q;
    cur_row_d  = cur_row_q;
    we_c       = 1'b0;
    waddr_c    = cur_addr_c;
    wdata_c    = ASC_SPACE;
    case (state_q)
      TB_CLEAR: begin
        we_c       = 1'b1;
        waddr_c    = clr_addr_q;
        wdata_c    = ASC_SPACE;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
          clr_addr_d = '0;
          state_d    = TB_IDLE;
        end
      end
      default: begin
        if (accept_c) begin
          if ((i_char >= ASC_SPACE) && (i_char <= ASC_TILDE)) begin
            we_c    = 1'b1;
            wdata_c = i_char;
            if (cur_col_q == COL_W'(COLS - 1)) begin
              cur_col_d = '0;
              cur_row_d = row_inc_c;
            end else begin
              cur_col_d = cur_col_q + COL_W'(1);
            end
          end else if (i_char == ASC_BS) begin
            if (cur_col_q != '0) begin
              we_c      = 1'b1;
              waddr_c   = ADDR_W'(cur_row_q) * ADDR_W'(COLS) + ADDR_W'(col_dec_c);
              cur_col_d = col_dec_c;
            end
          end else if (i_char == ASC_LF) begin
            cur_col_d = '0;
            cur_row_d = row_inc_c;
          end else if (i_char == ASC_FF) begin
            cur_col_d  = '0;
            cur_row_d  = '0;
            clr_addr_d = '0;
            state_d    = TB_CLEAR;
          end
        end
      end
    endcase
  end

  assign o_char_ready = ready_q;
  assign o_cur_col    = cur_col_q;
  assign o_cur_row    = cur_row_q;

  text_ram #(
    .DEPTH  (CELLS),
    .WIDTH  (CHAR_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (pix_clk),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_text_buffer.sv
// Directed self-checking bench for text_buffer.
module tb_text_buffer;

  logic        pix_clk = 1'b0;
  logic        rst_n;
  logic [11:0] i_x, i_y;
  logic        i_active;
  logic [11:0] o_x, o_y;
  logic        o_active;
  logic [6:0]  o_character;
  logic        i_char_valid;
  logic [6:0]  i_char;
  logic        o_char_ready;
  logic [5:0]  o_cur_col;
  logic [4:0]  o_cur_row;

  int n_tests = 0;
  int n_fail  = 0;
  int n;
  logic [6:0] ch;

  always #5 pix_clk = ~pix_clk;

  text_buffer #(.COLS(40), .ROWS(30)) dut (
    .pix_clk      (pix_clk),
    .rst_n        (rst_n),
    .i_x          (i_x),
    .i_y          (i_y),
    .i_active     (i_active),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_active     (o_active),
    .o_character  (o_character),
    .i_char_valid (i_char_valid),
    .i_char       (i_char),
    .o_char_ready (o_char_ready),
    .o_cur_col    (o_cur_col),
    .o_cur_row    (o_cur_row)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one character for a single accepted cycle.
  task automatic put(input logic [6:0] c);
    int t = 0;
    while (!o_char_ready && t < 3000) begin
      @(negedge pix_clk);
      t++;
    end
    if (!o_char_ready) chk("put_timeout", o_char_ready, 1);
    i_char_valid = 1'b1;
    i_char       = c;
    @(negedge pix_clk);
    i_char_valid = 1'b0;
  endtask

  task automatic rd(input int x, input int y, output logic [6:0] c);
    i_x      = 12'(x);
    i_y      = 12'(y);
    i_active = 1'b1;
    repeat (2) @(negedge pix_clk);
    c = o_character;
  endtask

  // Count cycles until ready rises; pixel (0,0) is probed mid-clear.
  task automatic wait_clear(output int cnt);
    cnt = 0;
    do begin
      @(negedge pix_clk);
      cnt++;
      if (cnt == 600) chk("clr_mid_char", o_character, 7'h20);
    end while (!o_char_ready && cnt < 3000);
  endtask

  initial begin
    rst_n = 1'b0; i_char_valid = 1'b0; i_char = 7'h00;
    i_x = 12'd5; i_y = 12'd3; i_active = 1'b1;
    repeat (3) @(negedge pix_clk);
    chk("rst_o_x", o_x, 0);
    chk("rst_o_y", o_y, 0);
    chk("rst_active", o_active, 0);
    chk("rst_char", o_character, 7'h20);
    chk("rst_ready", o_char_ready, 0);
    chk("rst_col", o_cur_col, 0);
    chk("rst_row", o_cur_row, 0);

    // 1: initial clear pass
    i_x = 12'd0; i_y = 12'd0;
    rst_n = 1'b1;
    wait_clear(n);
    chk("clr_len", n, 1200);
    rd(639, 479, ch); chk("clr_last_cell", ch, 7'h20);

    // 2: single write and pixel-aligned readback
    put(7'h31);
    rd(5, 3, ch);
    chk("w1_char", ch, 7'h31);
    chk("w1_o_x", o_x, 5);
    chk("w1_o_y", o_y, 3);
    chk("w1_active", o_active, 1);
    chk("w1_col", o_cur_col, 1);
    chk("w1_row", o_cur_row, 0);

    // 3: BS back to (0,0), then fill row 0
    put(7'h08);
    chk("bs_col", o_cur_col, 0);
    for (int i = 0; i < 40; i++) put(7'h32);
    chk("row_col", o_cur_col, 0);
    chk("row_row", o_cur_row, 1);
    rd(639, 15, ch); chk("row_last", ch, 7'h32);
    rd(0, 0, ch);    chk("row_first", ch, 7'h32);
    rd(640, 0, ch);  chk("oor_col", ch, 7'h20);
    rd(639, 16, ch); chk("row1_blank", ch, 7'h20);

    // 4: BS at column 0, print+BS, ignored code
    put(7'h08);
    chk("bs0_col", o_cur_col, 0);
    chk("bs0_row", o_cur_row, 1);
    put(7'h41);
    chk("a_col", o_cur_col, 1);
    put(7'h08);
    chk("abs_col", o_cur_col, 0);
    rd(0, 16, ch); chk("abs_cell", ch, 7'h20);
    put(7'h01);
    chk("ign_col", o_cur_col, 0);
    chk("ign_row", o_cur_row, 1);

    // 5: LF wrap, BS at (0,0), print wrap, FF clear
    for (int i = 0; i < 28; i++) put(7'h0A);
    chk("lf_row29", o_cur_row, 29);
    put(7'h0A);
    chk("lf_wrap_row", o_cur_row, 0);
    chk("lf_wrap_col", o_cur_col, 0);
    put(7'h08);
    chk("bs00_col", o_cur_col, 0);
    rd(0, 0, ch); chk("bs00_nowrite", ch, 7'h32);
    for (int i = 0; i < 29; i++) put(7'h0A);
    for (int i = 0; i < 39; i++) put(7'h5A);
    chk("pw_col39", o_cur_col, 39);
    chk("pw_row29", o_cur_row, 29);
    put(7'h5A);
    chk("pw_wrap_col", o_cur_col, 0);
    chk("pw_wrap_row", o_cur_row, 0);
    rd(639, 479, ch); chk("pw_last_cell", ch, 7'h5A);
    rd(0, 464, ch);   chk("pw_row29_c0", ch, 7'h5A);
    i_x = 12'd0; i_y = 12'd0;
    put(7'h0C);
    chk("ff_ready_low", o_char_ready, 0);
    wait_clear(n);
    chk("ff_len", n, 1200);
    rd(639, 479, ch); chk("ff_last_blank", ch, 7'h20);
    rd(0, 0, ch);     chk("ff_first_blank", ch, 7'h20);

    // 6: reset asserted mid-clear
    i_x = 12'd17; i_y = 12'd9;
    put(7'h0C);
    repeat (600) @(negedge pix_clk);
    chk("pre_rst_o_x", o_x, 17);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_x", o_x, 0);
    chk("mid_rst_o_y", o_y, 0);
    chk("mid_rst_active", o_active, 0);
    chk("mid_rst_char", o_character, 7'h20);
    chk("mid_rst_ready", o_char_ready, 0);
    @(negedge pix_clk);
    i_x = 12'd0; i_y = 12'd0;
    rst_n = 1'b1;
    wait_clear(n);
    chk("rst_clr_len", n, 1200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
